seq_restoring_divider: RTL and testbench

//  Sequential restoring divider: inverse of the 8x8 Wallace tree multiplier.

---
 rtl/seq_restoring_divider.sv | 139 +++++++++++++
 tb/tb_seq_restoring_divider.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_restoring_divider.sv
// Sequential restoring divider: produces one quotient bit per cycle, MSB first,
// with valid/ready handshakes on both the operand and the result side.
module seq_restoring_divider #(
    parameter int WZ = 16,
    parameter int WB = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [WZ-1:0] Z,
    input  logic [WB-1:0] B,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [WZ-1:0] Q,
    output logic [WB-1:0] R,
    output logic          ovf,
    output logic          dbz
);

    localparam int CW = $clog2(WZ);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [WZ-1:0] z_q, z_d;
    logic [WB-1:0] b_q, b_d;
    logic [WB:0]   p_q, p_d;
    logic [WZ-1:0] qw_q, qw_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [WZ-1:0] q_q, q_d;
    logic [WB-1:0] r_q, r_d;
    logic          ovf_q, ovf_d;
    logic          dbz_q, dbz_d;

    // One restoring step: shift the next dividend bit into the partial remainder
    logic [WB:0]   t_step;
    logic          t_ge;
    logic [WB:0]   p_step;
    logic [WZ-1:0] qw_step;

    always_comb begin
        t_step  = {p_q[WB-1:0], z_q[WZ-1]};
        t_ge    = (t_step >= {1'b0, b_q});
        p_step  = t_ge ? (t_step - {1'b0, b_q}) : t_step;
        qw_step = {qw_q[WZ-2:0], t_ge};
    end

    always_comb begin
        state_d = state_q;
        z_d     = z_q;
        b_d     = b_q;
        p_d     = p_q;
        qw_d    = qw_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        r_d     = r_q;
        ovf_d   = ovf_q;
        dbz_d   = dbz_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    z_d = Z;
                    b_d = B;
                    if (B != '0) begin
                        p_d     = '0;
                        qw_d    = '0;
                        cnt_d   = CW'(WZ - 1);
                        dbz_d   = 1'b0;
                        state_d = S_CALC;
                    end else begin
                        q_d     = '1;
                        r_d     = '0;
                        dbz_d   = 1'b1;
                        ovf_d   = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_CALC: begin
                z_d   = {z_q[WZ-2:0], 1'b0};
                p_d   = p_step;
                qw_d  = qw_step;
                cnt_d = cnt_q - 1'b1;
                // Results land in separate output registers so Q/R never show partial work
                if (cnt_q == '0) begin
                    q_d     = qw_step;
                    r_d     = p_step[WB-1:0];
                    ovf_d   = |qw_step[WZ-1:WB];
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            z_q     <= '0;
            b_q     <= '0;
            p_q     <= '0;
            qw_q    <= '0;
            cnt_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            ovf_q   <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            z_q     <= z_d;
            b_q     <= b_d;
            p_q     <= p_d;
            qw_q    <= qw_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            r_q     <= r_d;
            ovf_q   <= ovf_d;
            dbz_q   <= dbz_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign Q         = q_q;
    assign R         = r_q;
    assign ovf       = ovf_q;
    assign dbz       = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Bench for seq_restoring_divider: directed vector table, stall/reset corner
// sequences and a random sweep checked through a scoreboard queue.
module tb_seq_restoring_divider;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] Z;
    logic [7:0]  B;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] Q;
    logic [7:0]  R;
    logic        ovf;
    logic        dbz;

    seq_restoring_divider #(.WZ(16), .WB(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Z         (Z),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Q         (Q),
        .R         (R),
        .ovf       (ovf),
        .dbz       (dbz)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] z;
        logic [7:0]  b;
        logic [15:0] q;
        logic [7:0]  r;
        logic        ovf;
        logic        dbz;
        int          lat;
    } vec_t;

    vec_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    task automatic send(input vec_t v);
        int w;
        @(negedge clk);
        Z        = v.z;
        B        = v.b;
        in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        sb.push_back(v);
        #1;
        in_valid = 1'b0;
        Z        = 16'($urandom);
        B        = 8'($urandom);
    endtask

    task automatic collect();
        int   lat;
        vec_t e;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 40);
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'(sb.size()), 32'd1);
            return;
        end
        e = sb.pop_front();
        check("latency", 32'(lat), 32'(e.lat));
        check("Q", 32'(Q), 32'(e.q));
        check("R", 32'(R), 32'(e.r));
        check("ovf", 32'(ovf), 32'(e.ovf));
        check("dbz", 32'(dbz), 32'(e.dbz));
        if (!e.dbz) begin
            check("invariant_QB_R", 32'(Q) * 32'(e.b) + 32'(R), 32'(e.z));
            check("invariant_R_lt_B", 32'(R < e.b), 32'd1);
        end
        $display("txn Z=0x%04h B=0x%02h -> Q=0x%04h R=0x%02h ovf=%0d dbz=%0d lat=%0d",
                 e.z, e.b, Q, R, ovf, dbz, lat);
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("post_hs_in_ready", 32'(in_ready), 32'd1);
        check("post_hs_out_valid", 32'(out_valid), 32'd0);
    endtask

    function automatic vec_t model(input logic [15:0] z, input logic [7:0] b);
        vec_t v;
        v.z = z;
        v.b = b;
        if (b == 8'd0) begin
            v.q = 16'hFFFF; v.r = 8'd0; v.ovf = 1'b1; v.dbz = 1'b1; v.lat = 1;
        end else begin
            v.q   = z / 16'(b);
            v.r   = 8'(z % 16'(b));
            v.ovf = (v.q > 16'd255);
            v.dbz = 1'b0;
            v.lat = 17;
        end
        return v;
    endfunction

    vec_t tbl[9];

    initial begin
        logic [15:0] q_hold;
        logic [7:0]  r_hold;
        logic        stable;
        logic        saw;
        vec_t        v;

        tbl[0] = '{16'd15000, 8'd123,  16'd121,    8'd117, 1'b0, 1'b0, 17};
        tbl[1] = '{16'hFE01,  8'hFF,   16'h00FF,   8'd0,   1'b0, 1'b0, 17};
        tbl[2] = '{16'hFFFF,  8'hFF,   16'd257,    8'd0,   1'b1, 1'b0, 17};
        tbl[3] = '{16'h1234,  8'd0,    16'hFFFF,   8'd0,   1'b1, 1'b1, 1};
        tbl[4] = '{16'h0000,  8'd1,    16'h0000,   8'd0,   1'b0, 1'b0, 17};
        tbl[5] = '{16'hFFFF,  8'd1,    16'hFFFF,   8'd0,   1'b1, 1'b0, 17};
        tbl[6] = '{16'h00FF,  8'hFF,   16'h0001,   8'd0,   1'b0, 1'b0, 17};
        tbl[7] = '{16'h00FE,  8'hFF,   16'h0000,   8'hFE,  1'b0, 1'b0, 17};
        tbl[8] = '{16'd100,   8'd7,    16'd14,     8'd2,   1'b0, 1'b0, 17};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        Z         = '0;
        B         = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_Q", 32'(Q), 32'd0);
        check("rst_R", 32'(R), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_dbz", 32'(dbz), 32'd0);

        for (int i = 0; i < 9; i++) begin
            send(tbl[i]);
            collect();
            handshake();
        end

        // Result must hold while the consumer stalls
        send(tbl[0]);
        collect();
        q_hold = Q;
        r_hold = R;
        stable = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (Q !== q_hold || R !== r_hold || ovf !== 1'b0 || dbz !== 1'b0 ||
                out_valid !== 1'b1 || in_ready !== 1'b0)
                stable = 1'b0;
        end
        check("stall_stable", 32'(stable), 32'd1);
        check("stall_Q", 32'(Q), 32'd121);
        handshake();

        // Reset in the middle of the iteration discards the pending result
        send(tbl[0]);
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete(sb.size() - 1);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        saw = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) saw = 1'b1;
        end
        check("abort_no_result", 32'(saw), 32'd0);
        send(tbl[8]);
        collect();
        handshake();

        for (int i = 0; i < 2000; i++) begin
            logic [7:0]  rb;
            logic [15:0] rz;
            rb = 8'($urandom);
            if (i[1:0] == 2'd0) rz = 16'(rb) * 16'($urandom_range(0, 255));
            else                rz = 16'($urandom);
            v = model(rz, rb);
            send(v);
            collect();
            handshake();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
